// File: rtl/wb_write_arbiter_if.sv
// Writeback bus between the ALU/load sources, the arbiter and the register file ports.
// WB_BYPASS_EN adds the forwarding outputs fwd_one_*/fwd_two_*.
interface wb_write_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 1
);
  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_dest;
  logic [DATA_W-1:0] alu_data;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_dest;
  logic [DATA_W-1:0] mem_data;
  logic              rf_write_enable;
  logic [ADDR_W-1:0] rf_dest;
  logic [DATA_W-1:0] rf_data_in;
  logic [ADDR_W-1:0] src_one;
  logic [ADDR_W-1:0] src_two;
  logic              hazard_one;
  logic              hazard_two;
  logic              busy;
`ifdef WB_BYPASS_EN
  logic              fwd_one_valid;
  logic [DATA_W-1:0] fwd_one_data;
  logic              fwd_two_valid;
  logic [DATA_W-1:0] fwd_two_data;

  modport slave (
    input  alu_valid, alu_dest, alu_data, mem_valid, mem_dest, mem_data, src_one, src_two,
    output alu_ready, mem_ready, rf_write_enable, rf_dest, rf_data_in,
           hazard_one, hazard_two, busy,
           fwd_one_valid, fwd_one_data, fwd_two_valid, fwd_two_data
  );
  modport master (
    output alu_valid, alu_dest, alu_data, mem_valid, mem_dest, mem_data, src_one, src_two,
    input  alu_ready, mem_ready, rf_write_enable, rf_dest, rf_data_in,
           hazard_one, hazard_two, busy,
           fwd_one_valid, fwd_one_data, fwd_two_valid, fwd_two_data
  );
`else
  modport slave (
    input  alu_valid, alu_dest, alu_data, mem_valid, mem_dest, mem_data, src_one, src_two,
    output alu_ready, mem_ready, rf_write_enable, rf_dest, rf_data_in,
           hazard_one, hazard_two, busy
  );
  modport master (
    output alu_valid, alu_dest, alu_data, mem_valid, mem_dest, mem_data, src_one, src_two,
    input  alu_ready, mem_ready, rf_write_enable, rf_dest, rf_data_in,
           hazard_one, hazard_two, busy
  );
`endif
endinterface

// File: rtl/wb_write_arbiter.sv
// Writeback arbiter: one holding slot each for ALU and load results, one registered RF write per cycle.
// Optional WB_BYPASS_EN forwards the output stage to the read ports instead of flagging a hazard.
module wb_write_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 1,
  parameter int STARVE_MAX = 3
) (
  input  logic                clk,
  input  logic                rst,
  wb_write_arbiter_if.slave   bus
);
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic              alu_full, mem_full;
  logic [ADDR_W-1:0] alu_dest_q, mem_dest_q;
  logic [DATA_W-1:0] alu_data_q, mem_data_q;
  logic              alu_older;
  logic [SW-1:0]     starve_cnt;
  logic              we_q;
  logic [ADDR_W-1:0] dest_q;
  logic [DATA_W-1:0] data_q;

  logic alu_grant, mem_grant, alu_acc, mem_acc, alu_stay, mem_stay;

  // Grant is a function of registered state only, keeping valid off the ready path.
  always_comb begin
    alu_grant = 1'b0;
    mem_grant = 1'b0;
    if (alu_full && mem_full && (alu_dest_q == mem_dest_q)) begin
      alu_grant = alu_older;
      mem_grant = ~alu_older;
    end else if (alu_full && (!mem_full || starve_cnt == SW'(STARVE_MAX))) begin
      alu_grant = 1'b1;
    end else begin
      mem_grant = mem_full;
    end
  end

  assign bus.alu_ready = ~rst & (~alu_full | alu_grant);
  assign bus.mem_ready = ~rst & (~mem_full | mem_grant);
  assign alu_acc  = bus.alu_valid & bus.alu_ready;
  assign mem_acc  = bus.mem_valid & bus.mem_ready;
  assign alu_stay = alu_full & ~alu_grant;
  assign mem_stay = mem_full & ~mem_grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_full   <= 1'b0;
      mem_full   <= 1'b0;
      alu_dest_q <= '0;
      mem_dest_q <= '0;
      alu_data_q <= '0;
      mem_data_q <= '0;
      alu_older  <= 1'b1;
      starve_cnt <= '0;
      we_q       <= 1'b0;
      dest_q     <= '0;
      data_q     <= '0;
    end else begin
      if (alu_acc) begin
        alu_full   <= 1'b1;
        alu_dest_q <= bus.alu_dest;
        alu_data_q <= bus.alu_data;
      end else if (alu_grant) begin
        alu_full <= 1'b0;
      end
      if (mem_acc) begin
        mem_full   <= 1'b1;
        mem_dest_q <= bus.mem_dest;
        mem_data_q <= bus.mem_data;
      end else if (mem_grant) begin
        mem_full <= 1'b0;
      end
      // An entry that survives the edge is older than anything captured at it; same-edge ties go to ALU.
      if (!(alu_stay && mem_stay)) begin
        alu_older <= alu_stay | ~mem_stay;
      end
      if (!alu_full || alu_grant) begin
        starve_cnt <= '0;
      end else if (starve_cnt != SW'(STARVE_MAX)) begin
        starve_cnt <= starve_cnt + SW'(1);
      end
      we_q <= alu_grant | mem_grant;
      if (alu_grant) begin
        dest_q <= alu_dest_q;
        data_q <= alu_data_q;
      end else if (mem_grant) begin
        dest_q <= mem_dest_q;
        data_q <= mem_data_q;
      end
    end
  end

  assign bus.rf_write_enable = we_q;
  assign bus.rf_dest         = dest_q;
  assign bus.rf_data_in      = data_q;
  assign bus.busy            = alu_full | mem_full | we_q;

  logic slot_hit_one, slot_hit_two, out_hit_one, out_hit_two;

  always_comb begin
    slot_hit_one = (alu_full && alu_dest_q == bus.src_one) || (mem_full && mem_dest_q == bus.src_one);
    slot_hit_two = (alu_full && alu_dest_q == bus.src_two) || (mem_full && mem_dest_q == bus.src_two);
    out_hit_one  = we_q && (dest_q == bus.src_one);
    out_hit_two  = we_q && (dest_q == bus.src_two);
  end

`ifdef WB_BYPASS_EN
  assign bus.hazard_one    = slot_hit_one;
  assign bus.hazard_two    = slot_hit_two;
  assign bus.fwd_one_valid = out_hit_one;
  assign bus.fwd_two_valid = out_hit_two;
  assign bus.fwd_one_data  = data_q;
  assign bus.fwd_two_data  = data_q;
`else
  assign bus.hazard_one = slot_hit_one | out_hit_one;
  assign bus.hazard_two = slot_hit_two | out_hit_two;
`endif
endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter: scoreboard of expected RF writes plus cycle-exact checks.
// Expectations for the bypass configuration are selected with WB_BYPASS_EN.
module tb_wb_write_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_write_arbiter_if #(.DATA_W(32), .ADDR_W(1)) bus ();
  wb_write_arbiter #(.DATA_W(32), .ADDR_W(1), .STARVE_MAX(3)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct packed {
    logic [0:0]  dest;
    logic [31:0] data;
  } wr_t;

  wr_t sb[$];
  int  checks = 0;
  int  errors = 0;
  int  writes = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [0:0] d, input logic [31:0] v);
    wr_t e;
    e.dest = d;
    e.data = v;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rst && bus.rf_write_enable) begin
      wr_t e;
      writes++;
      if (sb.size() == 0) begin
        check("unexpected_write", 64'(bus.rf_write_enable), 64'd0);
      end else begin
        e = sb.pop_front();
        check("wr_dest", 64'(bus.rf_dest), 64'(e.dest));
        check("wr_data", 64'(bus.rf_data_in), 64'(e.data));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    bit alu_rdy_exp[8] = '{1, 0, 0, 0, 1, 1, 1, 1};
    bit mem_rdy_exp[8] = '{1, 1, 1, 1, 0, 1, 1, 1};
    int n;
    int wsave;

    bus.alu_valid = 1'b0; bus.alu_dest = '0; bus.alu_data = '0;
    bus.mem_valid = 1'b0; bus.mem_dest = '0; bus.mem_data = '0;
    bus.src_one = 1'b1;   bus.src_two = 1'b0;

    // Reset state
    repeat (2) tick();
    check("rst_we",    64'(bus.rf_write_enable), 64'd0);
    check("rst_dest",  64'(bus.rf_dest), 64'd0);
    check("rst_data",  64'(bus.rf_data_in), 64'd0);
    check("rst_busy",  64'(bus.busy), 64'd0);
    check("rst_aready", 64'(bus.alu_ready), 64'd0);
    check("rst_mready", 64'(bus.mem_ready), 64'd0);
    check("rst_haz1",  64'(bus.hazard_one), 64'd0);

    // Single ALU write: accept at N, strobe in the cycle after N+1
    rst = 1'b0;
    bus.alu_valid = 1'b1; bus.alu_dest = 1'b1; bus.alu_data = 32'hDEADBEEF;
    push(1'b1, 32'hDEADBEEF);
    #1;
    check("t1_aready", 64'(bus.alu_ready), 64'd1);
    tick();
    bus.alu_valid = 1'b0;
    check("t1_we_n", 64'(bus.rf_write_enable), 64'd0);
    check("t1_busy", 64'(bus.busy), 64'd1);
    check("t1_haz_slot", 64'(bus.hazard_one), 64'd1);
    tick();
    check("t1_we_n1", 64'(bus.rf_write_enable), 64'd1);
    check("t1_dest",  64'(bus.rf_dest), 64'd1);
    check("t1_data",  64'(bus.rf_data_in), 64'hDEADBEEF);
`ifdef WB_BYPASS_EN
    check("t1_haz_out", 64'(bus.hazard_one), 64'd0);
    check("t1_fwd_v",   64'(bus.fwd_one_valid), 64'd1);
    check("t1_fwd_d",   64'(bus.fwd_one_data), 64'hDEADBEEF);
`else
    check("t1_haz_out", 64'(bus.hazard_one), 64'd1);
`endif
    tick();
    check("t1_we_off", 64'(bus.rf_write_enable), 64'd0);
    check("t1_hold",   64'(bus.rf_data_in), 64'hDEADBEEF);
    check("t1_idle",   64'(bus.busy), 64'd0);
    check("t1_haz_clr", 64'(bus.hazard_one), 64'd0);

    // Same-edge offers with different dests: mem first
    bus.alu_valid = 1'b1; bus.alu_dest = 1'b0; bus.alu_data = 32'h11;
    bus.mem_valid = 1'b1; bus.mem_dest = 1'b1; bus.mem_data = 32'h22;
    push(1'b1, 32'h22);
    push(1'b0, 32'h11);
    check("t2_aready", 64'(bus.alu_ready), 64'd1);
    check("t2_mready", 64'(bus.mem_ready), 64'd1);
    tick();
    bus.alu_valid = 1'b0; bus.mem_valid = 1'b0;
    check("t2_mready_nostall", 64'(bus.mem_ready), 64'd1);
    tick();
    check("t2_first", 64'(bus.rf_data_in), 64'h22);
    tick();
    check("t2_second", 64'(bus.rf_data_in), 64'h11);
    check("t2_we2", 64'(bus.rf_write_enable), 64'd1);
    tick();
    check("t2_drain", 64'(sb.size()), 64'd0);

    // WAW: older ALU entry to r0 beats a younger load to r0
    bus.alu_valid = 1'b1; bus.alu_dest = 1'b0; bus.alu_data = 32'hAA;
    bus.mem_valid = 1'b1; bus.mem_dest = 1'b1; bus.mem_data = 32'h33;
    push(1'b1, 32'h33);
    push(1'b0, 32'hAA);
    push(1'b0, 32'hBB);
    tick();
    bus.alu_valid = 1'b0;
    bus.mem_dest = 1'b0; bus.mem_data = 32'hBB;
    check("t3_mready", 64'(bus.mem_ready), 64'd1);
    check("t3_haz2", 64'(bus.hazard_two), 64'd1);
    tick();
    bus.mem_valid = 1'b0;
    check("t3_w0", 64'(bus.rf_data_in), 64'h33);
    tick();
    check("t3_w1", 64'(bus.rf_data_in), 64'hAA);
    tick();
    check("t3_w2", 64'(bus.rf_data_in), 64'hBB);
    tick();
    check("t3_drain", 64'(sb.size()), 64'd0);

    // Starvation: continuous loads, one ALU offer forced through after 3 losses
    push(1'b1, 32'h100); push(1'b1, 32'h101); push(1'b1, 32'h102);
    push(1'b0, 32'h55);
    push(1'b1, 32'h103); push(1'b1, 32'h104); push(1'b1, 32'h105); push(1'b1, 32'h106);
    n = 0;
    for (int c = 0; c < 8; c++) begin
      bus.mem_valid = 1'b1; bus.mem_dest = 1'b1; bus.mem_data = 32'h100 + 32'(n);
      bus.alu_valid = (c == 0); bus.alu_dest = 1'b0; bus.alu_data = 32'h55;
      #1;
      check($sformatf("t4_aready_c%0d", c), 64'(bus.alu_ready), 64'(alu_rdy_exp[c]));
      check($sformatf("t4_mready_c%0d", c), 64'(bus.mem_ready), 64'(mem_rdy_exp[c]));
      if (c == 5) check("t4_alu_forced", 64'(bus.rf_data_in), 64'h55);
      if (mem_rdy_exp[c]) n++;
      tick();
    end
    bus.mem_valid = 1'b0; bus.alu_valid = 1'b0;
    repeat (3) tick();
    check("t4_drain", 64'(sb.size()), 64'd0);
    check("t4_idle", 64'(bus.busy), 64'd0);

    // Async reset mid-cycle with both slots full: held entries are dropped
    bus.alu_valid = 1'b1; bus.alu_dest = 1'b0; bus.alu_data = 32'h77;
    bus.mem_valid = 1'b1; bus.mem_dest = 1'b1; bus.mem_data = 32'h88;
    tick();
    bus.alu_valid = 1'b0; bus.mem_valid = 1'b0;
    check("t6_full", 64'(bus.busy), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("t6_we",   64'(bus.rf_write_enable), 64'd0);
    check("t6_busy", 64'(bus.busy), 64'd0);
    check("t6_data", 64'(bus.rf_data_in), 64'd0);
    check("t6_ready", 64'(bus.alu_ready), 64'd0);
    wsave = writes;
    tick();
    rst = 1'b0;
    repeat (4) tick();
    check("t6_no_write", 64'(writes), 64'(wsave));
    check("t6_idle", 64'(bus.busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
